// File: rtl/div_mon_pkg.sv
// Shared types and constants for the divided-clock ratio monitor.
package div_mon_pkg;

  localparam int CW_DEF  = 8;
  localparam int MATCH_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // All-ones value of a width-bit counter, used as the saturation ceiling.
  function automatic int sat_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Purpose: 2-flop synchroniser plus delay flop; exposes level, rise and fall of an async input.
// Latency: 2-3 clk cycles from input transition to rise/fall.
// Backpressure: none, free-running observer.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/div_ratio_monitor.sv
// Purpose: measures period/high time of a divided clock, reports lock, ratio match and stall.
// Latency: outputs update one clk after the synchronised edge (2-3 clk after div_in moves).
// Backpressure: none; period_valid is a single-cycle pulse with no handshake.
module div_ratio_monitor
  import div_mon_pkg::*;
#(
  parameter int CW         = CW_DEF,
  parameter int EXPECTED   = 14,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          div_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          period_valid,
  output logic          locked,
  output logic          ratio_ok,
  output logic          stalled,
  inout  wire           VDD,
  inout  wire           VSS
);

  localparam logic [CW-1:0]      CNT_MAX    = CW'(sat_max(CW));
  localparam logic [CW-1:0]      TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0]      EXPECTED_C = CW'(EXPECTED);
  localparam logic [MATCH_W-1:0] LOCK_C     = MATCH_W'(LOCK_COUNT);

  // Power pins carry no logic.
  wire pwr_unused;
  assign pwr_unused = VDD ^ VSS;

  logic lvl_unused, rise, fall;

  sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (div_in),
    .level (lvl_unused),
    .rise  (rise),
    .fall  (fall)
  );

  logic [CW-1:0]      pcnt, hcnt;
  logic [MATCH_W-1:0] match_cnt, match_inc, match_n;
  state_t             state, state_n;
  logic [CW-1:0]      period_n;
  logic               locked_n, stalled_n, valid_n, ratio_n, lock_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt      <= '0;
      hcnt      <= '0;
      high_time <= '0;
    end else begin
      if (rise) begin
        pcnt <= CW'(1);
        hcnt <= CW'(1);
      end else begin
        if (pcnt != CNT_MAX) pcnt <= pcnt + CW'(1);
        if (hcnt != CNT_MAX) hcnt <= hcnt + CW'(1);
      end
      if (fall) high_time <= hcnt;
    end
  end

  assign match_inc = (match_cnt == LOCK_C) ? LOCK_C : match_cnt + MATCH_W'(1);
  // The run length is match_inc+1 identical periods (the first one has no predecessor).
  assign lock_hit  = (int'(match_inc) >= LOCK_COUNT - 1);

  always_comb begin
    state_n   = state;
    period_n  = period;
    locked_n  = locked;
    match_n   = match_cnt;
    stalled_n = stalled;
    valid_n   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n   = MEASURE;
          stalled_n = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          valid_n  = 1'b1;
          period_n = pcnt;
          if (pcnt == period) begin
            match_n = match_inc;
            if (lock_hit) begin
              locked_n = 1'b1;
              state_n  = LOCKED;
            end
          end else begin
            match_n  = '0;
            locked_n = 1'b0;
          end
        end
      end
      LOCKED: begin
        if (rise) begin
          valid_n = 1'b1;
          if (pcnt != period) begin
            period_n = pcnt;
            locked_n = 1'b0;
            match_n  = '0;
            state_n  = MEASURE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // A rise in the same cycle as the timeout wins.
    if (state != IDLE && !rise && pcnt == TIMEOUT_C) begin
      stalled_n = 1'b1;
      locked_n  = 1'b0;
      match_n   = '0;
      state_n   = IDLE;
    end
    ratio_n = locked_n && (period_n == EXPECTED_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      period       <= '0;
      locked       <= 1'b0;
      match_cnt    <= '0;
      stalled      <= 1'b0;
      period_valid <= 1'b0;
      ratio_ok     <= 1'b0;
    end else begin
      state        <= state_n;
      period       <= period_n;
      locked       <= locked_n;
      match_cnt    <= match_n;
      stalled      <= stalled_n;
      period_valid <= valid_n;
      ratio_ok     <= ratio_n;
    end
  end

endmodule

// File: doc/div_ratio_monitor.md
Name: div_ratio_monitor

Overview:
- Receive-side companion to the team's clock dividers.
- Samples a divided clock signal (div_in) in the fast clk domain and measures its period and high time in clk cycles.
- Declares lock when the period is stable and flags whether the ratio matches the expected divide value.
- Sits beside each divider instance as a built-in self-check; outputs feed a status register / test pin.

Parameters:
- CW, 8, width of period/high-time counters and outputs.
- EXPECTED, 14, expected div_in period in clk cycles.
- LOCK_COUNT, 4, consecutive identical periods required to assert locked (1..15).
- TIMEOUT, 200, clk cycles with no div_in rising edge before declaring stall (must be < 2^CW).

Ports:
- clk  input  1  fast reference clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- div_in  input  1  divided clock under test; asynchronous to clk, synchronised internally.
- period  output  CW  last measured rising-to-rising period in clk cycles.
- high_time  output  CW  last measured rising-to-falling high time in clk cycles.
- period_valid  output  1  one-cycle pulse when period is updated.
- locked  output  1  period stable for LOCK_COUNT consecutive measurements.
- ratio_ok  output  1  locked AND period == EXPECTED.
- stalled  output  1  no rising edge for TIMEOUT cycles; held until next rising edge.
- VDD  inout  1  power pin, no logic.
- VSS  inout  1  ground pin, no logic.

Behaviour:
- Reset (reset=0, async): period=0, high_time=0, period_valid=0, locked=0, ratio_ok=0, stalled=0; synchroniser flops=0; counters=0; state=IDLE.
- Input path: 2-flop synchroniser (s1, s2), then a delay flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Latency from a div_in transition to rise/fall is 2–3 clk cycles; measurements are unaffected because every edge sees the same latency.
- Period counter pcnt:
  - On rise: pcnt <= 1.
  - Otherwise: pcnt <= pcnt + 1, saturating at 2^CW-1.
  - For a div_in of period P, the next rise sees pcnt == P.
- High counter hcnt: same rule, but cleared to 1 on rise and captured on fall (high_time <= hcnt on fall).
- States:
  - IDLE: ignore counts. On first rise → MEASURE (no period_valid).
  - MEASURE: on rise → period <= pcnt, period_valid=1 for that cycle.
    - If pcnt == previous period: match_cnt increments, saturating at LOCK_COUNT.
    - Otherwise: match_cnt <= 0 and locked <= 0.
    - When match_cnt reaches LOCK_COUNT-1 and this period matches, locked <= 1 → LOCKED.
  - LOCKED: on rise with pcnt == period → stay, period_valid pulses. On rise with pcnt != period → period updated, locked <= 0, match_cnt <= 0 → MEASURE.
  - Any state except IDLE: pcnt == TIMEOUT without a rise → stalled <= 1, locked <= 0, match_cnt <= 0 → IDLE.
- stalled clears on the next rise; that rise is treated as the first edge (IDLE→MEASURE, no measurement).
- ratio_ok is registered: ratio_ok <= (next locked) & (next period == EXPECTED), so it updates in the same cycle as locked.
- Simultaneous rise and timeout in the same cycle: rise wins, no stall.
- Glitch immunity is not provided; div_in pulses shorter than one clk cycle may be missed.
- high_time is captured independently of state; it is valid once a fall follows a rise.
- Reset mid-measurement discards everything; the first post-reset rise is treated as the first edge.

Decomposition:
- Package div_mon_pkg: state enum (IDLE, MEASURE, LOCKED); CW default; helper constant for counter saturation value.
- Sub-module sync_edge: 2-flop synchroniser plus delay flop, outputs level, rise and fall. Reusable by other monitors.

Test Plan:
- Reset check: hold reset=0 with div_in toggling → all outputs 0. Release reset → stalled=0 until TIMEOUT cycles elapse.
- Stable /14 input (7 high, 7 low): period_valid pulses every 14 cycles with period=14, high_time=7. locked=1 and ratio_ok=1 on the 5th rise after reset (1 first edge + 4 matching periods).
- Ratio mismatch: stable /12 (6/6) → period=12, high_time=6, locked=1, ratio_ok=0.
- Lock loss: locked on /14, then one period of 13 → at that rise period=13, locked=0, ratio_ok=0. Relock after 4 further matching periods.
- Stall: locked on /14, then freeze div_in low → stalled=1 exactly TIMEOUT=200 cycles after the last rise counter reload, locked=0. Resume toggling → stalled clears on the first rise, period_valid absent on that rise.
- Async reset mid-run: assert reset between clk edges while locked → outputs 0 immediately without a clk edge. Relock behaviour is identical to a fresh start.
